// File: rtl/scr1_scu_mc_pkg.sv
// scr1_scu_mc_pkg: op, register address and pulse FSM encodings for the multi-channel SCU
package scr1_scu_mc_pkg;
  localparam logic [2:0] SCU_ADDR_CONTROL    = 3'd0;
  localparam logic [2:0] SCU_ADDR_EXT_EN     = 3'd1;
  localparam logic [2:0] SCU_ADDR_STATUS     = 3'd2;
  localparam logic [2:0] SCU_ADDR_STICKY     = 3'd3;
  localparam logic [2:0] SCU_ADDR_PULSE_LEN  = 3'd4;
  localparam logic [2:0] SCU_ADDR_PULSE_TRIG = 3'd5;
  localparam logic [2:0] SCU_ADDR_ERR        = 3'd6;
  localparam logic [2:0] SCU_ADDR_RSVD       = 3'd7;
  typedef enum logic [1:0] {
    SCU_OP_WRITE   = 2'd0,
    SCU_OP_READ    = 2'd1,
    SCU_OP_SETBITS = 2'd2,
    SCU_OP_CLRBITS = 2'd3
  } scu_op_e;
  typedef enum logic [2:0] {
    SCU_REG_CONTROL    = SCU_ADDR_CONTROL,
    SCU_REG_EXT_EN     = SCU_ADDR_EXT_EN,
    SCU_REG_STATUS     = SCU_ADDR_STATUS,
    SCU_REG_STICKY     = SCU_ADDR_STICKY,
    SCU_REG_PULSE_LEN  = SCU_ADDR_PULSE_LEN,
    SCU_REG_PULSE_TRIG = SCU_ADDR_PULSE_TRIG,
    SCU_REG_ERR        = SCU_ADDR_ERR,
    SCU_REG_RSVD       = SCU_ADDR_RSVD
  } scu_addr_e;
  typedef enum logic {
    SCU_PULSE_IDLE,
    SCU_PULSE_ACTIVE
  } scu_pulse_state_e;
endpackage

// File: rtl/scr1_scu_mc_pulse.sv
// scr1_scu_mc_pulse: counter-timed reset pulse generator with length, mask and overflow strobe
module scr1_scu_mc_pulse
  import scr1_scu_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              len_we,
  input  logic              trig_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] len,
  output logic [NUM_CH-1:0] mask,
  output logic              busy,
  output logic              trig_ovf
);
  scu_pulse_state_e state, state_nxt;
  logic [DATA_W-1:0] cnt, cnt_nxt;
  logic trig, start;
  assign trig = trig_we & |wdata[NUM_CH-1:0];
  assign busy = state == SCU_PULSE_ACTIVE;
  always_comb begin
    start     = trig & ~busy;
    trig_ovf  = trig & busy;
    state_nxt = start ? SCU_PULSE_ACTIVE : (busy && cnt == '0) ? SCU_PULSE_IDLE : state;
    cnt_nxt   = start ? len : (busy && cnt != '0) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCU_PULSE_IDLE;
      cnt   <= '0;
      len   <= '0;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (len_we) len <= wdata;
      if (start) mask <= wdata[NUM_CH-1:0];
    end
  end
endmodule

// File: rtl/scr1_scu_mc.sv
// scr1_scu_mc: TAPC-accessed multi-channel reset controller with pulse generator and ext-request mask
module scr1_scu_mc
  import scr1_scu_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_ID  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tapc_ch_sel,
  input  logic              tapc_ch_id,
  input  logic              tapc_ch_capture,
  input  logic              tapc_ch_shift,
  input  logic              tapc_ch_update,
  input  logic              tapc_ch_tdi,
  output logic              tapc_ch_tdo,
  input  logic [NUM_CH-1:0] ext_rst_req,
  output logic [NUM_CH-1:0] ch_rst,
  output logic [NUM_CH-1:0] ch_rst_qlfy,
  output logic              pulse_busy
);
  localparam int DR_W = DATA_W + 5;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    scu_addr_e         addr;
    scu_op_e           op;
  } dr_t;
  dr_t shift_reg, shadow_reg;
  logic sel, cap, shf, upd, wr, clr_stk, clr_err, ovf, err;
  logic [DATA_W-1:0] rd_data, cmd_data, plen;
  logic [NUM_CH-1:0] control, ext_en, sticky, status_dly, mask;
  assign sel = tapc_ch_sel & (tapc_ch_id == 1'(CH_ID));
  assign cap = sel & tapc_ch_capture;
  assign shf = sel & tapc_ch_shift;
  assign upd = sel & tapc_ch_update;
  assign wr  = upd & (shift_reg.op != SCU_OP_READ);
  assign clr_stk = upd & (shift_reg.op == SCU_OP_CLRBITS) & (shift_reg.addr == SCU_REG_STICKY);
  assign clr_err = upd & (shift_reg.op == SCU_OP_CLRBITS) & (shift_reg.addr == SCU_REG_ERR);
  assign tapc_ch_tdo = shift_reg[0];
  always_comb begin
    case (shift_reg.addr)
      SCU_REG_CONTROL:    rd_data = DATA_W'(control);
      SCU_REG_EXT_EN:     rd_data = DATA_W'(ext_en);
      SCU_REG_STATUS:     rd_data = DATA_W'(ch_rst);
      SCU_REG_STICKY:     rd_data = DATA_W'(sticky);
      SCU_REG_PULSE_LEN:  rd_data = plen;
      SCU_REG_PULSE_TRIG: rd_data = pulse_busy ? DATA_W'(mask) : '0;
      SCU_REG_ERR:        rd_data = DATA_W'(err);
      default:            rd_data = '0;
    endcase
  end
  assign cmd_data = shift_reg.op == SCU_OP_WRITE   ? shift_reg.data :
                    shift_reg.op == SCU_OP_READ    ? rd_data :
                    shift_reg.op == SCU_OP_SETBITS ? rd_data | shift_reg.data :
                                                     rd_data & ~shift_reg.data;
  // All reset sources are OR'ed with no priority between them
  assign ch_rst_qlfy = control | (pulse_busy ? mask : '0) | (ext_rst_req & ext_en);
  scr1_scu_mc_pulse #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) i_pulse (
    .clk      (clk),
    .rst      (rst),
    .len_we   (wr & (shift_reg.addr == SCU_REG_PULSE_LEN)),
    .trig_we  (wr & (shift_reg.addr == SCU_REG_PULSE_TRIG)),
    .wdata    (cmd_data),
    .len      (plen),
    .mask     (mask),
    .busy     (pulse_busy),
    .trig_ovf (ovf)
  );
  // status_dly resets to ones so the reset-release fall of ch_rst never sets sticky bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      shadow_reg <= '0;
      control    <= '0;
      ext_en     <= '1;
      sticky     <= '0;
      status_dly <= '1;
      err        <= 1'b0;
      ch_rst     <= '1;
    end else begin
      shift_reg  <= cap ? shadow_reg : shf ? {tapc_ch_tdi, shift_reg[DR_W-1:1]} : shift_reg;
      if (upd) shadow_reg <= {cmd_data, shift_reg.addr, shift_reg.op};
      if (wr && shift_reg.addr == SCU_REG_CONTROL) control <= cmd_data[NUM_CH-1:0];
      if (wr && shift_reg.addr == SCU_REG_EXT_EN) ext_en <= cmd_data[NUM_CH-1:0];
      sticky     <= (clr_stk ? cmd_data[NUM_CH-1:0] : sticky) | (ch_rst & ~status_dly);
      err        <= (clr_err ? cmd_data[0] : err) | ovf;
      status_dly <= ch_rst;
      ch_rst     <= ch_rst_qlfy;
    end
  end
endmodule

// File: tb/tb_scr1_scu_mc.sv
// tb_scr1_scu_mc: randomized TAPC traffic checked every cycle against a behavioural SCU model
module tb_scr1_scu_mc;
  localparam int NC = 4, DW = 8, DRW = DW + 5;
  logic clk = 0, rst = 1, sel = 0, cid = 0, cap_s = 0, shf = 0, upd = 0, tdi = 0;
  logic tdo, busy;
  logic [NC-1:0] ext = '0, ch_rst, qlfy;
  int errors = 0, checks = 0, busy_cnt = 0, rst1_cnt = 0;
  logic [1:0] m_op = 0;
  logic [2:0] m_addr = 0;
  logic [DW-1:0] m_data = 0;
  logic [NC-1:0] m_ctl = 0, m_een = '1, m_stk = 0, m_rst = '1, m_dly = '1, m_msk = 0;
  logic [DW-1:0] m_len = 0;
  logic m_err = 0;
  int m_rem = 0;
  logic [DRW-1:0] m_shadow = 0;

  always #5 clk = ~clk;

  scr1_scu_mc #(.NUM_CH(NC), .DATA_W(DW), .CH_ID(0)) dut (
    .clk(clk), .rst(rst), .tapc_ch_sel(sel), .tapc_ch_id(cid), .tapc_ch_capture(cap_s),
    .tapc_ch_shift(shf), .tapc_ch_update(upd), .tapc_ch_tdi(tdi), .tapc_ch_tdo(tdo),
    .ext_rst_req(ext), .ch_rst(ch_rst), .ch_rst_qlfy(qlfy), .pulse_busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] m_qlfy();
    return m_ctl | (m_rem > 0 ? m_msk : '0) | (ext & m_een);
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [2:0] a);
    case (a)
      0: return {4'h0, m_ctl};
      1: return {4'h0, m_een};
      2: return {4'h0, m_rst};
      3: return {4'h0, m_stk};
      4: return m_len;
      5: return m_rem > 0 ? {4'h0, m_msk} : 8'h0;
      6: return {7'h0, m_err};
      default: return 8'h0;
    endcase
  endfunction

  // Register-level model: one call per rising clock edge
  task automatic m_step();
    logic [NC-1:0] q, rise, stk;
    logic [DW-1:0] rv, cd;
    logic was_busy, ovf, e;
    if (rst) begin
      m_ctl = 0; m_een = '1; m_stk = 0; m_rst = '1; m_dly = '1; m_msk = 0;
      m_len = 0; m_err = 0; m_rem = 0; m_shadow = 0;
      return;
    end
    q = m_qlfy(); rise = m_rst & ~m_dly; was_busy = m_rem > 0;
    rv = m_rd(m_addr); ovf = 0; stk = m_stk; e = m_err;
    if (was_busy) m_rem--;
    if (sel && !cid && upd) begin
      case (m_op)
        0: cd = m_data;
        1: cd = rv;
        2: cd = rv | m_data;
        default: cd = rv & ~m_data;
      endcase
      m_shadow = {cd, m_addr, m_op};
      if (m_op != 1)
        case (m_addr)
          0: m_ctl = cd[NC-1:0];
          1: m_een = cd[NC-1:0];
          3: if (m_op == 3) stk = cd[NC-1:0];
          4: m_len = cd;
          5: if (cd[NC-1:0] != 0) begin
               if (was_busy) ovf = 1;
               else begin m_rem = int'(m_len) + 1; m_msk = cd[NC-1:0]; end
             end
          6: if (m_op == 3) e = cd[0];
          default: ;
        endcase
    end
    m_stk = stk | rise; m_err = e | ovf; m_dly = m_rst; m_rst = q;
  endtask

  initial forever begin
    @(posedge clk);
    m_step();
    #1;
    chk("ch_rst", 32'(ch_rst), 32'(m_rst));
    chk("ch_rst_qlfy", 32'(qlfy), 32'(m_qlfy()));
    chk("pulse_busy", 32'(busy), 32'(m_rem > 0));
  end

  always @(posedge clk) begin
    #2;
    if (busy) busy_cnt++;
    if (ch_rst[1]) rst1_cnt++;
  end

  task automatic cmd(input logic [1:0] op, input logic [2:0] a, input logic [DW-1:0] d,
                     input logic id, output logic [DRW-1:0] cap);
    logic [DRW-1:0] v, exp;
    v = {d, a, op};
    @(negedge clk); sel = 1; cid = id; cap_s = 1; exp = m_shadow;
    @(negedge clk); cap_s = 0; shf = 1;
    for (int i = 0; i < DRW; i++) begin
      tdi = v[i]; cap[i] = tdo;
      @(negedge clk);
    end
    shf = 0; upd = 1; m_op = op; m_addr = a; m_data = d;
    @(negedge clk); upd = 0; sel = 0; cid = 0;
    if (!id) chk("dr_capture", 32'(cap), 32'(exp));
  endtask

  task automatic wr(input logic [1:0] op, input logic [2:0] a, input logic [DW-1:0] d);
    logic [DRW-1:0] c;
    cmd(op, a, d, 1'b0, c);
  endtask

  task automatic rd(input logic [2:0] a, output logic [DW-1:0] d);
    logic [DRW-1:0] c;
    cmd(2'd1, a, 8'h0, 1'b0, c);
    cmd(2'd1, 3'd7, 8'h0, 1'b0, c);
    d = c[DRW-1:5];
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DRW-1:0] c;
    int b0, r0;
    repeat (3) @(negedge clk);
    chk("rst_ch_rst", 32'(ch_rst), 32'hF);
    rst = 0;
    @(negedge clk);
    chk("release_ch_rst", 32'(ch_rst), 32'h0);
    rd(3'd3, d); chk("sticky_after_release", 32'(d), 32'h0);
    wr(2'd0, 3'd0, 8'h05);
    chk("qlfy_leads", 32'(qlfy), 32'h5);
    chk("ch_rst_lags", 32'(ch_rst), 32'h0);
    @(negedge clk);
    chk("ch_rst_ctrl", 32'(ch_rst), 32'h5);
    rd(3'd2, d); chk("status_read", 32'(d), 32'h05);
    wr(2'd2, 3'd3, 8'h0F);
    rd(3'd3, d); chk("sticky_setbits_noop", 32'(d), 32'h05);
    wr(2'd3, 3'd3, 8'h01);
    rd(3'd3, d); chk("sticky_clr", 32'(d), 32'h04);
    wr(2'd0, 3'd0, 8'h00);
    cmd(2'd0, 3'd0, 8'h0F, 1'b1, c);
    rd(3'd0, d); chk("other_chain_ignored", 32'(d), 32'h0);
    wr(2'd0, 3'd4, 8'd3);
    b0 = busy_cnt; r0 = rst1_cnt;
    wr(2'd0, 3'd5, 8'h02);
    repeat (10) @(negedge clk);
    chk("pulse_busy_len", 32'(busy_cnt - b0), 32'd4);
    chk("pulse_ch1_len", 32'(rst1_cnt - r0), 32'd4);
    wr(2'd0, 3'd4, 8'd40);
    b0 = busy_cnt;
    wr(2'd0, 3'd5, 8'h02);
    wr(2'd0, 3'd5, 8'h01);
    repeat (45) @(negedge clk);
    chk("pulse_not_extended", 32'(busy_cnt - b0), 32'd41);
    rd(3'd6, d); chk("err_set", 32'(d), 32'h01);
    wr(2'd3, 3'd6, 8'h01);
    rd(3'd6, d); chk("err_clr", 32'(d), 32'h00);
    wr(2'd0, 3'd1, 8'h0E);
    ext = 4'h3;
    repeat (2) @(negedge clk);
    chk("ext_masked", 32'(ch_rst), 32'h2);
    ext = 4'h0;
    for (int n = 0; n < 120; n++) begin
      logic [1:0] op;
      logic [2:0] a;
      op = 2'($urandom_range(0, 3));
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd4) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      ext = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      cmd(op, a, d, $urandom_range(0, 7) == 0, c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1; @(negedge clk); rst = 0;
      end
    end
    ext = 4'h0;
    wr(2'd0, 3'd4, 8'd50);
    wr(2'd0, 3'd5, 8'h01);
    chk("busy_before_rst", 32'(busy), 32'h1);
    rst = 1;
    #1;
    chk("busy_async_rst", 32'(busy), 32'h0);
    chk("ch_rst_async_rst", 32'(ch_rst), 32'hF);
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
